project_sel_ctrl: RTL and testbench
===================================

PROJECT_SEL_CTRL -- requirements
Module: project_sel_ctrl

Interface
REQ-001 SHALL have parameter NUM_PROJ, default 24: number of selectable projects; legal addresses are 0..NUM_PROJ-1.
REQ-002 SHALL have parameter GUARD_CYCLES, default 4, range 1..15: number of cycles ena is held low around every address change.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port sel_inc  input  1  synchronous level; each rising edge requests addr+1.
REQ-006 SHALL have port sel_load  input  1  synchronous single-cycle strobe; load sel_addr_in.
REQ-007 SHALL have port sel_addr_in  input  5  target address for sel_load.
REQ-008 SHALL have port sel_ena_req  input  1  level; request that the selected project be enabled.
REQ-009 SHALL have port addr  output  5  registered project address to the project mux.
REQ-010 SHALL have port ena  output  1  registered enable to the project mux.
REQ-011 SHALL have port busy  output  1  high while in GUARD.
REQ-012 SHALL have port err  output  1  sticky flag for an illegal load address.

Function
REQ-013 SHALL detect a sel_inc rising edge as sel_inc=1 with previous-cycle sel_inc=0; a held-high sel_inc SHALL produce exactly one increment.
REQ-014 SHALL implement FSM states IDLE (ena=0), GUARD (ena=0, busy=1), ACTIVE (ena=1).
REQ-015 SHALL change addr only on the edge that enters or restarts GUARD; ena SHALL be 0 on that same cycle and for GUARD_CYCLES cycles in total.
REQ-016 Increment SHALL wrap: addr=NUM_PROJ-1 plus increment gives addr=0.
REQ-017 sel_load with sel_addr_in<NUM_PROJ SHALL set addr=sel_addr_in; with sel_addr_in>=NUM_PROJ SHALL leave addr and state unchanged and set err=1.
REQ-018 Simultaneous sel_load and sel_inc edge: load SHALL win; the increment SHALL be dropped.
REQ-019 IDLE: valid inc/load -> GUARD; sel_ena_req=1 and no inc/load -> ACTIVE on the next edge.
REQ-020 GUARD: guard counter SHALL load GUARD_CYCLES-1 on entry and decrement each cycle; at 0 -> ACTIVE if sel_ena_req=1, else IDLE.
REQ-021 A valid inc/load while in GUARD SHALL update addr immediately and restart the counter at GUARD_CYCLES-1.
REQ-022 ACTIVE: valid inc/load -> GUARD, with ena=0 on the same edge addr changes; sel_ena_req=0 -> IDLE with ena=0 on the next edge.
REQ-023 An invalid load SHALL not cause a state transition in any state.
REQ-024 err SHALL clear only on reset.

Reset
REQ-025 rst_n=0 SHALL immediately force addr=0, ena=0, busy=0, err=0, state=IDLE, guard counter=0, and the edge-detect register=0.
REQ-026 Reset asserted during GUARD or ACTIVE SHALL abort the operation with no further output change until release.
REQ-027 After reset release, sel_inc already high SHALL count as one rising edge on the first clock.

Verification
REQ-028 Reset, then sel_ena_req=1 -> ena=1 after 1 clock, addr=0.
REQ-029 ACTIVE at addr=3, one sel_inc edge -> same edge addr=4 and ena=0; busy=1 for 4 cycles; ena=1 on the 5th cycle.
REQ-030 addr=23, sel_inc edge -> addr=0; sel_inc held high for 10 cycles -> exactly one increment.
REQ-031 sel_load with sel_addr_in=30 in ACTIVE at addr=5 -> addr stays 5, ena stays 1, err=1 until reset.
REQ-032 sel_inc edge and sel_load=1 with sel_addr_in=7 on the same cycle at addr=2 -> addr=7.
REQ-033 Second sel_inc at guard cycle 2 -> addr increments again; ena stays 0 for a further 4 full cycles; rst_n=0 mid-GUARD -> addr=0, ena=0 asynchronously.

Source files
------------

// File: rtl/project_sel_ctrl.sv
// Project select controller.
// Drives a registered project address and enable to an external project mux.
// Every address change takes ena low on the same edge and keeps it low for
// GUARD_CYCLES cycles (state GUARD, busy=1) before ena may rise again.
//
// Handshake note: there is no valid/ready pair on this block. sel_load is a
// one-cycle strobe that is always accepted when sel_addr_in is legal. sel_inc
// is a level; only its rising edge requests an increment. sel_ena_req is a
// level that is sampled on every cycle the FSM can act on it.
//
// dbg_state exposes the FSM state so that checkers can bind to it.
module project_sel_ctrl #(
  parameter int NUM_PROJ     = 24,
  parameter int GUARD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel_inc,
  input  logic       sel_load,
  input  logic [4:0] sel_addr_in,
  input  logic       sel_ena_req,
  output logic [4:0] addr,
  output logic       ena,
  output logic       busy,
  output logic       err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GUARD  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYCLES - 1);
  localparam logic [4:0] LAST_ADDR  = 5'(NUM_PROJ - 1);
  localparam logic [5:0] NUM_PROJ_W = 6'(NUM_PROJ);

  state_t     state, state_d;
  logic [4:0] addr_d;
  logic [3:0] gcnt, gcnt_d;
  logic       inc_prev;
  logic       inc_edge;
  logic       load_ok;
  logic       load_bad;
  logic       change;
  logic [4:0] new_addr;

  // Decode requests: a load always masks a coincident increment edge.
  always_comb begin
    inc_edge = sel_inc & ~inc_prev;
    load_ok  = sel_load & ({1'b0, sel_addr_in} < NUM_PROJ_W);
    load_bad = sel_load & ~load_ok;
    change   = load_ok | (inc_edge & ~sel_load);
    if (load_ok) begin
      new_addr = sel_addr_in;
    end else if (addr == LAST_ADDR) begin
      new_addr = 5'd0;
    end else begin
      new_addr = addr + 5'd1;
    end
  end

  // Next-state: any accepted change (re)enters GUARD; otherwise follow sel_ena_req.
  always_comb begin
    state_d = state;
    addr_d  = addr;
    gcnt_d  = gcnt;
    if (change) begin
      addr_d  = new_addr;
      state_d = GUARD;
      gcnt_d  = GUARD_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (sel_ena_req) state_d = ACTIVE;
        end
        GUARD: begin
          if (gcnt == 4'd0) begin
            state_d = sel_ena_req ? ACTIVE : IDLE;
          end else begin
            gcnt_d = gcnt - 4'd1;
          end
        end
        ACTIVE: begin
          if (!sel_ena_req) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, outputs and edge-detect register; ena/busy are registered from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= 5'd0;
      gcnt     <= 4'd0;
      ena      <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      inc_prev <= 1'b0;
    end else begin
      state    <= state_d;
      addr     <= addr_d;
      gcnt     <= gcnt_d;
      ena      <= (state_d == ACTIVE);
      busy     <= (state_d == GUARD);
      err      <= err | load_bad;
      inc_prev <= sel_inc;
    end
  end

  // Debug view of the FSM state.
  always_comb begin
    dbg_state = state;
  end

endmodule

// File: tb/tb_project_sel_ctrl.sv
// Testbench for project_sel_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_project_sel_ctrl;

  localparam int NUM_PROJ     = 24;
  localparam int GUARD_CYCLES = 4;

  logic       clk;
  logic       rst_n;
  logic       sel_inc;
  logic       sel_load;
  logic [4:0] sel_addr_in;
  logic       sel_ena_req;
  logic [4:0] addr;
  logic       ena;
  logic       busy;
  logic       err;
  logic [1:0] dbg_state;

  project_sel_ctrl #(
    .NUM_PROJ    (NUM_PROJ),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_inc    (sel_inc),
    .sel_load   (sel_load),
    .sel_addr_in(sel_addr_in),
    .sel_ena_req(sel_ena_req),
    .addr       (addr),
    .ena        (ena),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  // guard_left counts the remaining ena-low cycles after an address change.
  int m_addr;
  int m_guard_left;
  bit m_ena;
  bit m_err;
  bit m_prev_inc;

  logic [7:0] exp_q[$];

  function automatic void model_reset();
    m_addr       = 0;
    m_guard_left = 0;
    m_ena        = 0;
    m_err        = 0;
    m_prev_inc   = 0;
  endfunction

  function automatic void model_step();
    bit rise;
    bit moved;
    int target;
    rise   = sel_inc && !m_prev_inc;
    moved  = 0;
    target = m_addr;
    m_prev_inc = sel_inc;
    if (sel_load) begin
      if (int'(sel_addr_in) < NUM_PROJ) begin
        moved  = 1;
        target = int'(sel_addr_in);
      end else begin
        m_err = 1;
      end
    end else if (rise) begin
      moved  = 1;
      target = (m_addr + 1) % NUM_PROJ;
    end
    if (moved) begin
      m_addr       = target;
      m_guard_left = GUARD_CYCLES;
      m_ena        = 0;
    end else if (m_guard_left > 0) begin
      m_guard_left = m_guard_left - 1;
      if (m_guard_left == 0) m_ena = sel_ena_req;
    end else begin
      m_ena = sel_ena_req;
    end
    exp_q.push_back({5'(m_addr), m_ena, (m_guard_left > 0), m_err});
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_vals(input string name, input logic [7:0] want);
    logic [7:0] got;
    got = {addr, ena, busy, err};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got addr=%0d ena=%b busy=%b err=%b, want addr=%0d ena=%b busy=%b err=%b",
               name, got[7:3], got[2], got[1], got[0], want[7:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic check_model(input string name);
    logic [7:0] want;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expected queue empty", name);
    end else begin
      want = exp_q.pop_front();
      check_vals(name, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic inc, input logic load, input logic [4:0] ain, input logic req);
    sel_inc     = inc;
    sel_load    = load;
    sel_addr_in = ain;
    sel_ena_req = req;
  endtask

  // One clock: model sees the same inputs the DUT samples, then compare.
  task automatic tick(input string name);
    model_step();
    @(posedge clk);
    #1;
    check_model(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    check_vals("reset_values", 8'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       inc;
    logic       load;
    logic [4:0] ain;
    logic       req;
    logic [4:0] ea;
    logic       ee;
    logic       eb;
    logic       er;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic inc, input logic load, input logic [4:0] ain,
                              input logic req, input logic [4:0] ea, input logic ee,
                              input logic eb, input logic er);
    vec_t v;
    v.inc = inc; v.load = load; v.ain = ain; v.req = req;
    v.ea = ea; v.ee = ee; v.eb = eb; v.er = er;
    tbl.push_back(v);
  endfunction

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 5'd0, 0);
    model_reset();

    // inc load ain req | addr ena busy err
    add(0, 0, 5'd0,  1,  5'd0,  1, 0, 0); // enable after one clock at addr 0
    add(0, 1, 5'd3,  1,  5'd3,  0, 1, 0); // load 3: ena drops same edge
    add(0, 0, 5'd0,  1,  5'd3,  0, 1, 0);
    add(0, 0, 5'd0,  1,  5'd3,  0, 1, 0);
    add(0, 0, 5'd0,  1,  5'd3,  0, 1, 0);
    add(0, 0, 5'd0,  1,  5'd3,  1, 0, 0); // ACTIVE at addr 3
    add(1, 0, 5'd0,  1,  5'd4,  0, 1, 0); // inc edge: addr 4, ena 0
    add(0, 0, 5'd0,  1,  5'd4,  0, 1, 0);
    add(0, 0, 5'd0,  1,  5'd4,  0, 1, 0);
    add(0, 0, 5'd0,  1,  5'd4,  0, 1, 0); // 4th busy cycle
    add(0, 0, 5'd0,  1,  5'd4,  1, 0, 0); // ena on 5th cycle
    add(0, 1, 5'd30, 1,  5'd4,  1, 0, 1); // illegal load: no change, err
    add(0, 1, 5'd23, 0,  5'd23, 0, 1, 1); // load last address
    add(1, 0, 5'd0,  0,  5'd0,  0, 1, 1); // wrap, restart guard
    add(1, 0, 5'd0,  0,  5'd0,  0, 1, 1); // held high: no further inc
    add(1, 0, 5'd0,  0,  5'd0,  0, 1, 1);
    add(1, 0, 5'd0,  0,  5'd0,  0, 1, 1);
    add(1, 0, 5'd0,  0,  5'd0,  0, 0, 1); // guard ends, no req -> IDLE
    add(0, 0, 5'd0,  0,  5'd0,  0, 0, 1);
    add(0, 1, 5'd2,  0,  5'd2,  0, 1, 1); // load 2
    add(1, 1, 5'd7,  0,  5'd7,  0, 1, 1); // load wins over inc edge
    add(0, 0, 5'd0,  0,  5'd7,  0, 1, 1);

    do_reset();
    foreach (tbl[i]) begin
      set_in(tbl[i].inc, tbl[i].load, tbl[i].ain, tbl[i].req);
      tick($sformatf("model_row%0d", i));
      check_vals($sformatf("table_row%0d", i), {tbl[i].ea, tbl[i].ee, tbl[i].eb, tbl[i].er});
    end

    // ---- held-high increment: exactly one step over 10 cycles ----
    do_reset();
    set_in(1, 0, 5'd0, 0);
    for (int i = 0; i < 10; i++) tick("inc_held");
    check_vals("inc_held_once", {5'd1, 1'b0, 1'b0, 1'b0});

    // ---- second inc mid-GUARD restarts the full guard window ----
    set_in(0, 0, 5'd0, 1);
    tick("pre_active");
    set_in(1, 0, 5'd0, 1);
    tick("first_inc");
    set_in(0, 0, 5'd0, 1);
    tick("guard_c1");
    set_in(1, 0, 5'd0, 1);
    tick("second_inc");
    check_vals("second_inc_addr", {5'd3, 1'b0, 1'b1, 1'b0});
    set_in(0, 0, 5'd0, 1);
    for (int i = 0; i < 3; i++) tick("guard_restart");
    check_vals("guard_still_low", {5'd3, 1'b0, 1'b1, 1'b0});
    tick("guard_done");
    check_vals("ena_after_restart", {5'd3, 1'b1, 1'b0, 1'b0});

    // ---- asynchronous reset mid-GUARD, held, then release with inc high ----
    set_in(0, 1, 5'd9, 1);
    tick("load9");
    set_in(0, 0, 5'd0, 1);
    tick("guard_mid");
    #2;
    rst_n = 1'b0;
    #1;
    check_vals("async_reset", 8'b0);
    set_in(1, 0, 5'd0, 1);
    repeat (3) @(posedge clk);
    #1;
    check_vals("reset_held", 8'b0);
    model_reset();
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    tick("inc_at_release");
    check_vals("inc_at_release_addr", {5'd1, 1'b0, 1'b1, 1'b0});

    // ---- randomized run against the model ----
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic inc_n;
      logic load_n;
      logic [4:0] ain_n;
      logic req_n;
      inc_n  = ($urandom_range(0, 3) == 0) ? ~sel_inc : sel_inc;
      load_n = ($urandom_range(0, 9) == 0);
      ain_n  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31))
                                           : 5'($urandom_range(0, 23));
      req_n  = ($urandom_range(0, 4) != 0);
      set_in(inc_n, load_n, ain_n, req_n);
      tick($sformatf("rand%0d", i));
      if (i == 300) begin
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
